// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding, NOP encoding and default watchdog limit for hazard_ctrl
package hazard_pkg;
  typedef enum logic {RUN, WAIT} state_e;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam int DEF_MEM_TIMEOUT = 16;
endpackage

// File: rtl/dmem_wait_fsm.sv
// dmem_wait_fsm: data-memory handshake FSM with watchdog and sticky timeout flag
module dmem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic mem_access_i,
  input  logic dmem_ready_i,
  output logic freeze_o,
  output logic dmem_valid_o,
  output logic mem_err_o
);
  localparam int WD_W = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);
  state_e state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic err_q, err_d;
  logic run, timeout;
  // next state: ready always beats the watchdog, which fires on the MEM_TIMEOUT-th WAIT cycle
  always_comb begin
    run          = state_q == RUN;
    timeout      = (MEM_TIMEOUT > 0) && !run && !dmem_ready_i && wd_q == WD_LAST;
    freeze_o     = run ? mem_access_i && !dmem_ready_i : !dmem_ready_i && !timeout;
    dmem_valid_o = !rst_i && (run ? mem_access_i : 1'b1);
    state_d      = freeze_o ? WAIT : RUN;
    wd_d         = run ? '0 : wd_q + 1'b1;
    err_d        = err_q || timeout;
  end
  // state, watchdog and sticky error registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end
  assign mem_err_o = err_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush controller; HAZARD_PERF_EN builds the performance counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memRead,
  input  logic             ex_branch_taken,
  input  logic             imem_ready,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             dmem_valid,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  logic frz, go, load_use, hold;
  dmem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_fsm (
    .clk_i       (CLK),
    .rst_i       (RST),
    .mem_access_i(mem_access),
    .dmem_ready_i(dmem_ready),
    .freeze_o    (frz),
    .dmem_valid_o(dmem_valid),
    .mem_err_o   (mem_err)
  );
  // priority: reset/freeze, then taken branch, then load-use or fetch wait, else advance
  always_comb begin
    go          = !RST && !frz;
    load_use    = ex_memRead && ex_rd != 5'd0 &&
                  ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    hold        = load_use || !imem_ready;
    pc_we       = go && (ex_branch_taken || !hold);
    if_id_we    = pc_we;
    id_ex_we    = go;
    ex_mem_we   = go;
    mem_wb_we   = go;
    if_id_flush = go && ex_branch_taken;
    id_ex_flush = go && (ex_branch_taken || hold);
  end
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  // counters wrap naturally at 2^CNT_W
  always_comb begin
    stall_d = pc_we ? stall_q : stall_q + CNT_W'(1);
    flush_d = if_id_flush ? flush_q + CNT_W'(1) : flush_q;
  end
  // counter registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif
endmodule
